// File: rtl/ddr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr_pkg : command encodings, FSM states and address masks for ddr_init_seq
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package ddr_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  localparam logic [12:0] A10_ALL_BANKS = 13'h400;
  localparam logic [12:0] MR_DLL_RESET  = 13'h100;

  localparam logic [2:0] LAST_STEP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_READY = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_init_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr_init_seq : DDR SDRAM power-up command sequencer driving an external timer
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module ddr_init_seq
  import ddr_pkg::*;
#(
  parameter int          TIMER_BITS = 16,
  parameter int          T_PWR      = 20000,
  parameter int          T_RP       = 3,
  parameter int          T_MRD      = 2,
  parameter int          T_DLL      = 200,
  parameter int          T_RFC      = 8,
  parameter logic [12:0] MODE_REG   = 13'h032,
  parameter logic [12:0] EXT_MODE   = 13'h000,
  parameter int          TIMEOUT    = 65535
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  init_i,
  output logic                  start_o,
  output logic [TIMER_BITS-1:0] count_o,
  input  logic                  done_i,
  output logic [3:0]            cmd_o,
  output logic [1:0]            ba_o,
  output logic [12:0]           addr_o,
  output logic                  ready_o,
  output logic                  error_o
);

  localparam int     CW      = $clog2(TIMEOUT + 1);
  localparam longint DLY_LIM = longint'(1) << TIMER_BITS;
  localparam int     MAX_DLY = max_int(max_int(max_int(T_PWR, T_RP), max_int(T_MRD, T_DLL)), T_RFC);

  localparam logic [TIMER_BITS-1:0] D_PWR = TIMER_BITS'(T_PWR);
  localparam logic [TIMER_BITS-1:0] D_RP  = TIMER_BITS'(T_RP);
  localparam logic [TIMER_BITS-1:0] D_MRD = TIMER_BITS'(T_MRD);
  localparam logic [TIMER_BITS-1:0] D_DLL = TIMER_BITS'(T_DLL);
  localparam logic [TIMER_BITS-1:0] D_RFC = TIMER_BITS'(T_RFC);

  generate
    if (longint'(MAX_DLY) >= DLY_LIM) begin : g_delay_overflow
      $error("ddr_init_seq: a delay does not fit in TIMER_BITS");
    end
    if (TIMEOUT < MAX_DLY + 2) begin : g_timeout_short
      $error("ddr_init_seq: TIMEOUT shorter than largest delay + 2");
    end
  endgenerate

  state_t                  state;
  logic [2:0]              step;
  logic [CW-1:0]           wait_cnt;

  logic [2:0]              issue_step;
  logic [3:0]              tbl_cmd;
  logic [1:0]              tbl_ba;
  logic [12:0]             tbl_addr;
  logic [TIMER_BITS-1:0]   tbl_delay;

  // Entry for the step about to be issued: step 0 from IDLE, otherwise the next one.
  always_comb begin
    issue_step = (state == ST_IDLE) ? 3'd0 : step + 3'd1;
    tbl_cmd    = CMD_NOP;
    tbl_ba     = 2'd0;
    tbl_addr   = 13'd0;
    tbl_delay  = D_PWR;
    case (issue_step)
      3'd0: begin tbl_cmd = CMD_NOP;  tbl_delay = D_PWR; end
      3'd1: begin tbl_cmd = CMD_PRE;  tbl_addr = A10_ALL_BANKS; tbl_delay = D_RP; end
      3'd2: begin tbl_cmd = CMD_LMR;  tbl_ba = 2'd1; tbl_addr = EXT_MODE; tbl_delay = D_MRD; end
      3'd3: begin tbl_cmd = CMD_LMR;  tbl_addr = MODE_REG | MR_DLL_RESET; tbl_delay = D_DLL; end
      3'd4: begin tbl_cmd = CMD_PRE;  tbl_addr = A10_ALL_BANKS; tbl_delay = D_RP; end
      3'd5: begin tbl_cmd = CMD_AREF; tbl_delay = D_RFC; end
      3'd6: begin tbl_cmd = CMD_AREF; tbl_delay = D_RFC; end
      3'd7: begin tbl_cmd = CMD_LMR;  tbl_addr = MODE_REG; tbl_delay = D_MRD; end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= ST_IDLE;
      step     <= 3'd0;
      wait_cnt <= '0;
      start_o  <= 1'b0;
      count_o  <= '0;
      cmd_o    <= CMD_DESEL;
      ba_o     <= 2'd0;
      addr_o   <= 13'd0;
      ready_o  <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      start_o <= 1'b0;
      count_o <= '0;
      ba_o    <= 2'd0;
      addr_o  <= 13'd0;
      cmd_o   <= CMD_NOP;
      case (state)
        ST_IDLE: begin
          if (init_i) begin
            state   <= ST_ISSUE;
            step    <= issue_step;
            start_o <= 1'b1;
            count_o <= tbl_delay;
            cmd_o   <= tbl_cmd;
            ba_o    <= tbl_ba;
            addr_o  <= tbl_addr;
          end else begin
            cmd_o <= CMD_DESEL;
          end
        end
        ST_ISSUE: begin
          state    <= ST_WAIT;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          // First WAIT cycle ignores done_i: the timer may still show its previous done.
          if (wait_cnt != '0 && done_i) begin
            if (step == LAST_STEP) begin
              state   <= ST_READY;
              ready_o <= 1'b1;
            end else begin
              state   <= ST_ISSUE;
              step    <= issue_step;
              start_o <= 1'b1;
              count_o <= tbl_delay;
              cmd_o   <= tbl_cmd;
              ba_o    <= tbl_ba;
              addr_o  <= tbl_addr;
            end
          end else if (wait_cnt == CW'(TIMEOUT)) begin
            state   <= ST_ERROR;
            error_o <= 1'b1;
            ready_o <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ST_READY: ready_o <= 1'b1;
        ST_ERROR: begin
          error_o <= 1'b1;
          ready_o <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          cmd_o <= CMD_DESEL;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
